// File: rtl/shl_seq.sv
// Sequential 32-bit shifter: one bit per clock, logical shift left or rotate left.
// Result and carry_out are latched on entry to DONE and held until the next completion.
module shl_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] operand,
  input  logic [4:0]  shift_amount,
  input  logic        rotate,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rot_q, rot_d;
  logic        carry_q, carry_d;
  logic        cout_q, cout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    rot_d    = rot_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = operand;
          cnt_d   = shift_amount;
          rot_d   = rotate;
          carry_d = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // start is deliberately not looked at here: an in-flight op cannot be restarted
        if (cnt_q != 5'd0) begin
          acc_d   = {acc_q[30:0], rot_q ? acc_q[31] : 1'b0};
          carry_d = acc_q[31];
          cnt_d   = cnt_q - 5'd1;
        end else begin
          result_d = acc_q;
          cout_d   = carry_q;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the state being entered
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      rot_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      rot_q    <= rot_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
